// File: rtl/pulse_meter.sv
// Pulse-width meter: measures the next complete high pulse on an async input
// and hands the width to a consumer over a valid/ready handshake.
module pulse_meter #(
  parameter int MAX_COUNT   = 100,
  parameter int SYNC_STAGES = 2,
  localparam int W = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  input  logic         arm,
  input  logic         abort,
  input  logic         meas_ready,
  output logic         meas_valid,
  output logic [W-1:0] meas_width,
  output logic         meas_ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    COUNT,
    REPORT
  } state_t;

  localparam logic [W-1:0] MAXV = W'(MAX_COUNT);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   sync_d;
  logic                   rise;

  state_t         state, state_n;
  logic [W-1:0]   count, count_n;
  logic           ovf, ovf_n;
  logic [W-1:0]   width_n;
  logic           movf_n;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~sync_d;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_d <= sync;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    ovf_n   = ovf;
    width_n = meas_width;
    movf_n  = meas_ovf;
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
      ovf_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          // A level already high at arm time never produces a rise here.
          if (rise) begin
            count_n = ONE;
            ovf_n   = 1'b0;
            state_n = COUNT;
          end
        end
        COUNT: begin
          if (sync) begin
            if (count == MAXV) ovf_n = 1'b1;
            else               count_n = count + ONE;
          end else begin
            width_n = count;
            movf_n  = ovf;
            state_n = REPORT;
          end
        end
        REPORT: begin
          if (meas_ready) state_n = arm ? WAIT_RISE : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      ovf        <= 1'b0;
      meas_width <= '0;
      meas_ovf   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      ovf        <= ovf_n;
      meas_width <= width_n;
      meas_ovf   <= movf_n;
      meas_valid <= (state_n == REPORT);
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed scenarios plus random pulses
// compared against widths computed from the pulse lengths driven.
module tb_pulse_meter;

  localparam int SS = 2;
  localparam int M0 = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       meas_ready = 1'b0;

  logic       v0, o0, b0;
  logic [6:0] w0;
  logic       v1, o1, b1;
  logic [0:0] w1;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  pulse_meter #(.MAX_COUNT(M0), .SYNC_STAGES(SS)) u0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .arm(arm),
    .abort(abort), .meas_ready(meas_ready), .meas_valid(v0),
    .meas_width(w0), .meas_ovf(o0), .busy(b0)
  );

  pulse_meter #(.MAX_COUNT(1), .SYNC_STAGES(SS)) u1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .arm(arm),
    .abort(abort), .meas_ready(meas_ready), .meas_valid(v1),
    .meas_width(w1), .meas_ovf(o1), .busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, {31'd0, v0}, 0);
    chk({tag, "_w0"}, {25'd0, w0}, 0);
    chk({tag, "_o0"}, {31'd0, o0}, 0);
    chk({tag, "_b0"}, {31'd0, b0}, 0);
    chk({tag, "_v1"}, {31'd0, v1}, 0);
    chk({tag, "_w1"}, {31'd0, w1}, 0);
    chk({tag, "_o1"}, {31'd0, o1}, 0);
    chk({tag, "_b1"}, {31'd0, b1}, 0);
  endtask

  // One full measurement: optional arm, pulse of n edges, rdly cycles of
  // back-pressure, then handshake with arm=rearm on the same edge.
  task automatic measure(input int n, input int rdly, input bit rearm,
                         input bit need_arm);
    int lat;
    int e0, e1;
    bit f0, f1;
    e0 = (n < M0) ? n : M0;
    f0 = (n > M0);
    e1 = 1;
    f1 = (n > 1);
    if (need_arm) begin
      arm = 1'b1;
      step(1);
      arm = 1'b0;
    end
    meas_ready = 1'($urandom % 2);
    step(SS + 2);
    meas_ready = 1'b0;
    chk("busy_armed", {31'd0, b0}, 1);
    sig_in = 1'b1;
    step(n);
    sig_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= SS + 10; k++) begin
      step(1);
      if (v0 === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, SS + 1);
    chk("valid_u1", {31'd0, v1}, 1);
    chk("width_u0", {25'd0, w0}, e0);
    chk("ovf_u0", {31'd0, o0}, {31'd0, f0});
    chk("width_u1", {31'd0, w1}, e1);
    chk("ovf_u1", {31'd0, o1}, {31'd0, f1});
    for (int i = 0; i < rdly; i++) begin
      sig_in = (i < rdly - (SS + 2)) ? 1'($urandom % 2) : 1'b0;
      step(1);
      chk("hold_valid", {31'd0, v0}, 1);
      chk("hold_width", {25'd0, w0}, e0);
      chk("hold_ovf", {31'd0, o0}, {31'd0, f0});
    end
    sig_in = 1'b0;
    meas_ready = 1'b1;
    arm = rearm;
    step(1);
    meas_ready = 1'b0;
    arm = 1'b0;
    chk("valid_drop", {31'd0, v0}, 0);
    chk("busy_after", {31'd0, b0}, {31'd0, rearm});
    chk("busy_after_u1", {31'd0, b1}, {31'd0, rearm});
    armed = rearm;
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", {31'd0, b0}, 0);

    measure(7, 3, 1'b0, 1'b1);
    measure(150, 0, 1'b0, 1'b1);
    measure(1, 0, 1'b0, 1'b1);
    measure(2, 1, 1'b0, 1'b1);
    measure(100, 0, 1'b0, 1'b1);
    measure(101, 0, 1'b0, 1'b1);
    measure(9, 20, 1'b1, 1'b1);
    measure(12, 0, 1'b0, 1'b0);

    // arm while the input is already high
    sig_in = 1'b1;
    step(5);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(3);
    chk("armhigh_busy", {31'd0, b0}, 1);
    sig_in = 1'b0;
    step(SS + 4);
    chk("armhigh_novalid", {31'd0, v0}, 0);
    measure(12, 2, 1'b0, 1'b0);

    // abort while counting
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(SS + 2);
    sig_in = 1'b1;
    step(6);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", {31'd0, b0}, 0);
    chk("abort_busy_u1", {31'd0, b1}, 0);
    chk("abort_valid", {31'd0, v0}, 0);
    sig_in = 1'b0;
    step(SS + 4);
    chk("abort_novalid", {31'd0, v0}, 0);
    chk("abort_novalid_u1", {31'd0, v1}, 0);

    // reset while reporting
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(SS + 2);
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(SS + 1);
    chk("pre_rst_valid", {31'd0, v0}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    step(1);
    rst_n = 1'b1;
    step(SS + 2);
    sig_in = 1'b1;
    step(4);
    sig_in = 1'b0;
    step(SS + 4);
    chk("noarm_valid", {31'd0, v0}, 0);
    chk("noarm_busy", {31'd0, b0}, 0);
    armed = 1'b0;

    for (int t = 0; t < 25; t++) begin
      measure(int'($urandom_range(1, 130)), int'($urandom_range(0, 8)),
              1'($urandom % 2), !armed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
